// File: rtl/instruction_fetch_pkg.sv
// Shared fetch/parser definitions: word and address widths, reset PC,
// buffer depth and the fetch control state encoding.
package instruction_fetch_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int ADDRESS_WIDTH     = 8;
    localparam int RESET_PC          = 0;
    localparam int FIFO_DEPTH        = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch stage's control, memory and decode-side signals.
// master: the fetch stage; slave: the core/memory/decode environment.
interface instruction_fetch_if #(
    parameter int INSTRUCTION_WIDTH = instruction_fetch_pkg::INSTRUCTION_WIDTH,
    parameter int ADDRESS_WIDTH     = instruction_fetch_pkg::ADDRESS_WIDTH
);
    import instruction_fetch_pkg::*;

    logic                         fetchEnable;
    logic                         memRequest;
    logic [ADDRESS_WIDTH-1:0]     memAddress;
    logic                         memAccept;
    logic                         memResponseValid;
    logic [INSTRUCTION_WIDTH-1:0] memResponseData;
    logic                         redirectValid;
    logic [ADDRESS_WIDTH-1:0]     redirectAddress;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic [ADDRESS_WIDTH-1:0]     instructionPc;
    logic                         instructionValid;
    logic                         instructionReady;
    logic                         busy;

    modport master (
        input  fetchEnable, memAccept, memResponseValid, memResponseData,
               redirectValid, redirectAddress, instructionReady,
        output memRequest, memAddress, instruction, instructionPc,
               instructionValid, busy
    );

    modport slave (
        output fetchEnable, memAccept, memResponseValid, memResponseData,
               redirectValid, redirectAddress, instructionReady,
        input  memRequest, memAddress, instruction, instructionPc,
               instructionValid, busy
    );

endinterface

// File: rtl/instruction_fetch_fetch_fifo.sv
// Small synchronous FIFO with push/pop/flush and an occupancy count.
// Used both for the fetched-word buffer and for the in-flight PC tags.
module fetch_fifo import instruction_fetch_pkg::*; #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = FIFO_DEPTH,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_eff, pop_eff;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer/count update; flush wins, simultaneous push+pop at full is allowed
    always_comb begin
        pop_eff  = pop_i && (count_q != '0);
        push_eff = push_i && ((count_q != CW'(DEPTH)) || pop_eff);
        wr_d     = wr_q;
        rd_d     = rd_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push_eff) wr_d = ptr_inc(wr_q);
            if (pop_eff)  rd_d = ptr_inc(rd_q);
            count_d = count_q + CW'(push_eff) - CW'(pop_eff);
        end
    end

    // Control registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage; contents are only meaningful while counted, so no reset
    always_ff @(posedge clk_i) begin
        if (push_eff && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word reads with a credit limit, tags
// each read with its PC, buffers returned words and hands the head word to
// decode. Redirects flush the buffer and drop still-in-flight responses.
module instruction_fetch import instruction_fetch_pkg::*; #(
    parameter int INSTRUCTION_WIDTH = instruction_fetch_pkg::INSTRUCTION_WIDTH,
    parameter int ADDRESS_WIDTH     = instruction_fetch_pkg::ADDRESS_WIDTH,
    parameter int RESET_PC          = instruction_fetch_pkg::RESET_PC,
    parameter int FIFO_DEPTH        = instruction_fetch_pkg::FIFO_DEPTH
) (
    input logic                 clock,
    input logic                 resetN,
    instruction_fetch_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = INSTRUCTION_WIDTH + ADDRESS_WIDTH;

    fetch_state_e             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]            drop_q, drop_d;
    logic [CW-1:0]            outstanding, fifo_count;
    logic [ADDRESS_WIDTH-1:0] tag_pc;
    logic [EW-1:0]            head;
    logic                     accept, resp, fifo_push, fifo_pop, head_valid;

    // Credits cover both in-flight reads and buffered words, so a returning
    // word always finds a free slot even if decode never consumes.
    assign bus.memRequest = (state_q == RUN) && !bus.redirectValid &&
                            (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
    assign accept     = bus.memRequest && bus.memAccept;
    assign resp       = bus.memResponseValid && (outstanding != '0);
    assign fifo_push  = resp && (drop_q == '0) && !bus.redirectValid;
    assign head_valid = (fifo_count != '0);
    assign fifo_pop   = head_valid && bus.instructionReady;

    fetch_fifo #(.WIDTH(ADDRESS_WIDTH), .DEPTH(FIFO_DEPTH)) u_tag_q (
        .clk_i   (clock),
        .rst_ni  (resetN),
        .push_i  (accept),
        .pop_i   (resp),
        .flush_i (1'b0),
        .wdata_i (pc_q),
        .rdata_o (tag_pc),
        .count_o (outstanding)
    );

    fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_instr_q (
        .clk_i   (clock),
        .rst_ni  (resetN),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (bus.redirectValid),
        .wdata_i ({bus.memResponseData, tag_pc}),
        .rdata_o (head),
        .count_o (fifo_count)
    );

    assign bus.memAddress       = pc_q;
    assign bus.instructionValid = head_valid;
    assign bus.instruction      = head_valid ? head[EW-1:ADDRESS_WIDTH] : '0;
    assign bus.instructionPc    = head_valid ? head[ADDRESS_WIDTH-1:0] : '0;
    assign bus.busy             = (state_q != IDLE) || (outstanding != '0);

    // Next state, next PC and stale-response drop counter
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE:    if (bus.fetchEnable) state_d = RUN;
            RUN:     if (!bus.fetchEnable) state_d = DRAIN;
            DRAIN: begin
                if (bus.fetchEnable)         state_d = RUN;
                else if (outstanding == '0)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.redirectValid) begin
            // Every read still in flight after this cycle's response is stale
            pc_d   = bus.redirectAddress;
            drop_d = outstanding - CW'(resp);
        end else begin
            if (accept)                  pc_d   = pc_q + 1'b1;
            if (resp && drop_q != '0)    drop_d = drop_q - 1'b1;
        end
    end

    // State, PC and drop counter registers
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            pc_q    <= ADDRESS_WIDTH'(RESET_PC);
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    // A response with nothing outstanding breaks the memory protocol
    a_no_orphan_resp: assert property (@(posedge clock) disable iff (!resetN)
        !(bus.memResponseValid && (outstanding == '0)));

endmodule
